// File: rtl/gshare_pht.sv
// gshare pattern history table: 2^IDX_W saturating counters indexed by req_addr ^ GHR,
// registered prediction with same-cycle update bypass, reset sweep and mispredict counter.
module gshare_pht #(
  parameter int unsigned IDX_W    = 8,
  parameter int unsigned CTR_W    = 2,
  parameter int unsigned HIST_W   = 8,
  parameter int unsigned INIT_CTR = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [IDX_W-1:0]  req_addr,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [IDX_W-1:0]  pred_index,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_index,
  input  logic              upd_taken,
  input  logic              upd_mispredict,
  output logic              busy,
  output logic [HIST_W-1:0] ghr,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int unsigned      DEPTH    = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT_CTR);

  typedef enum logic {SWEEP, RUN} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  sweep_ptr_q, sweep_ptr_d;
  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic [CNT_W-1:0]  miss_q, miss_d;
  logic              pred_valid_q, pred_valid_d;
  logic              pred_taken_q, pred_taken_d;
  logic [IDX_W-1:0]  pred_index_q, pred_index_d;

  logic [CTR_W-1:0]  ctr_q [DEPTH];

  logic              tbl_we;
  logic [IDX_W-1:0]  tbl_waddr;
  logic [CTR_W-1:0]  tbl_wdata;
  logic              upd_fire;
  logic [IDX_W-1:0]  req_idx;
  logic [CTR_W-1:0]  upd_cur, upd_new, req_ctr;

  always_comb begin
    state_d      = state_q;
    sweep_ptr_d  = sweep_ptr_q;
    ghr_d        = ghr_q;
    miss_d       = miss_q;
    pred_valid_d = 1'b0;
    pred_taken_d = pred_taken_q;
    pred_index_d = pred_index_q;
    tbl_we       = 1'b0;
    tbl_waddr    = sweep_ptr_q;
    tbl_wdata    = CTR_INIT;

    upd_fire = (state_q == RUN) && upd_valid;
    req_idx  = req_addr ^ IDX_W'(ghr_q);
    upd_cur  = ctr_q[upd_index];
    if (upd_taken)
      upd_new = (upd_cur == '1) ? upd_cur : upd_cur + CTR_W'(1);
    else
      upd_new = (upd_cur == '0) ? upd_cur : upd_cur - CTR_W'(1);
    // Bypass: a same-cycle update to the requested entry is visible to the prediction.
    req_ctr = (upd_fire && (upd_index == req_idx)) ? upd_new : ctr_q[req_idx];

    case (state_q)
      SWEEP: begin
        tbl_we      = 1'b1;
        sweep_ptr_d = sweep_ptr_q + IDX_W'(1);
        if (sweep_ptr_q == '1)
          state_d = RUN;
      end
      RUN: begin
        if (upd_fire) begin
          tbl_we    = 1'b1;
          tbl_waddr = upd_index;
          tbl_wdata = upd_new;
          ghr_d     = (ghr_q << 1) | HIST_W'(upd_taken);
          if (upd_mispredict && (miss_q != '1))
            miss_d = miss_q + CNT_W'(1);
        end
        pred_valid_d = req_valid;
        if (req_valid) begin
          pred_taken_d = req_ctr[CTR_W-1];
          pred_index_d = req_idx;
        end
      end
      default: state_d = SWEEP;
    endcase

    if (rst)
      tbl_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SWEEP;
      sweep_ptr_q  <= '0;
      ghr_q        <= '0;
      miss_q       <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_index_q <= '0;
    end else begin
      state_q      <= state_d;
      sweep_ptr_q  <= sweep_ptr_d;
      ghr_q        <= ghr_d;
      miss_q       <= miss_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_index_q <= pred_index_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tbl_we)
      ctr_q[tbl_waddr] <= tbl_wdata;
  end

  assign busy       = (state_q == SWEEP);
  assign ghr        = ghr_q;
  assign miss_cnt   = miss_q;
  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign pred_index = pred_index_q;

endmodule
